uart_transmitter: RTL

- UART transmit side of the UART-LED link; it is the far-end counterpart of the receive path that produces Rx_DATA/Rx_VALID/Rx_PERROR/Rx_FERROR.
- Accepts one byte per write handshake and serialises it onto TxD as an 8E1 frame: start bit, 8 data bits LSB first, even parity bit, stop bit.
- Contains its own baud tick generator with 8 selectable rates.
- Sits between the byte source (LED/test pattern logic) and the TxD pad.

---
 rtl/uart_transmitter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// 8E1 UART transmitter with an internal baud tick generator (16 ticks per bit).
// Optional 1-entry holding register enabled by defining UART_TX_HOLD_BUF_EN.
module uart_transmitter #(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic       Tx_WR,
    input  logic       Tx_EN,
    input  logic [2:0] baud_select,
    output logic       TxD,
    output logic       Tx_BUSY
);

    function automatic int unsigned calc_div(input int unsigned baud);
        return (CLK_FREQ + 8 * baud) / (16 * baud);
    endfunction

    localparam int unsigned DIV_MAX = calc_div(300);
    localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t             r_state;
    logic [7:0]         r_data;
    logic               r_parity;
    logic [2:0]         r_baud;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [3:0]         r_tick_cnt;
    logic [2:0]         r_bit_idx;
    logic               r_txd;
    logic               r_busy;

    state_t             w_state_next;
    logic [2:0]         w_bit_idx_next;
    logic               w_txd_next;
    logic               w_busy_next;
    logic [DIV_W-1:0]   w_div_last;
    logic               w_tick;
    logic               w_bit_end;
    logic               w_frame_done;
    logic               w_accept;
    logic               w_start;
    logic [7:0]         w_start_data;
    logic [2:0]         w_start_baud;

    always_comb begin
        w_div_last = '0;
        case (r_baud)
            3'd0: w_div_last = DIV_W'(calc_div(300) - 1);
            3'd1: w_div_last = DIV_W'(calc_div(1200) - 1);
            3'd2: w_div_last = DIV_W'(calc_div(4800) - 1);
            3'd3: w_div_last = DIV_W'(calc_div(9600) - 1);
            3'd4: w_div_last = DIV_W'(calc_div(19200) - 1);
            3'd5: w_div_last = DIV_W'(calc_div(38400) - 1);
            3'd6: w_div_last = DIV_W'(calc_div(57600) - 1);
            default: w_div_last = DIV_W'(calc_div(115200) - 1);
        endcase
    end

    assign w_tick       = (r_div_cnt == w_div_last);
    assign w_bit_end    = w_tick && (r_tick_cnt == 4'hF);
    assign w_frame_done = (r_state == ST_STOP) && w_bit_end;

`ifdef UART_TX_HOLD_BUF_EN
    logic       r_hold_full;
    logic [7:0] r_hold_data;
    logic [2:0] r_hold_baud;
    logic       w_from_hold;
    logic       w_hold_store;
    logic       w_hold_full_next;

    // A write landing on the final STOP cycle with an empty buffer starts directly.
    assign w_accept     = Tx_WR & Tx_EN & ~r_hold_full;
    assign w_from_hold  = r_hold_full & w_frame_done;
    assign w_start      = w_from_hold | (w_accept & ((r_state == ST_IDLE) | w_frame_done));
    assign w_hold_store = w_accept & ~w_start;
    assign w_start_data = w_from_hold ? r_hold_data : Tx_DATA;
    assign w_start_baud = w_from_hold ? r_hold_baud : baud_select;

    always_comb begin
        w_hold_full_next = r_hold_full;
        if (w_from_hold) begin
            w_hold_full_next = 1'b0;
        end else if (w_hold_store) begin
            w_hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_baud <= '0;
        end else begin
            r_hold_full <= w_hold_full_next;
            if (w_hold_store) begin
                r_hold_data <= Tx_DATA;
                r_hold_baud <= baud_select;
            end
        end
    end

    assign w_busy_next = (w_state_next != ST_IDLE) | w_hold_full_next;
`else
    assign w_accept     = Tx_WR & Tx_EN & ~r_busy;
    assign w_start      = w_accept;
    assign w_start_data = Tx_DATA;
    assign w_start_baud = baud_select;
    assign w_busy_next  = (w_state_next != ST_IDLE);
`endif

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_next = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) w_state_next = w_start ? ST_START : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // TxD is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            ST_START:  w_txd_next = 1'b0;
            ST_DATA:   w_txd_next = r_data[w_bit_idx_next];
            ST_PARITY: w_txd_next = r_parity;
            default:   w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_baud     <= '0;
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_txd     <= w_txd_next;
            r_busy    <= w_busy_next;
            if (w_start) begin
                r_data     <= w_start_data;
                r_parity   <= ^w_start_data;
                r_baud     <= w_start_baud;
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
            end else if (r_state != ST_IDLE) begin
                if (w_tick) begin
                    r_div_cnt  <= '0;
                    r_tick_cnt <= r_tick_cnt + 4'd1;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign TxD     = r_txd;
    assign Tx_BUSY = r_busy;

endmodule
